// File: rtl/spi_ram_responder.sv
// SPI mode-0 slave emulating a 23LC-style serial SRAM (READ/WRITE, sequential auto-increment).
// All SPI pins are oversampled in the clk domain; no logic is clocked by spi_clk.
//
// state     | meaning
// ST_IDLE   | waiting for chip select to fall
// ST_CMD    | shifting in the 8-bit opcode
// ST_ADDR   | shifting in the ADDR_W-bit start address
// ST_READ   | shifting memory bytes out on spi_miso, prefetching the next byte
// ST_WRITE  | assembling data bytes and issuing write strobes
// ST_IGNORE | unknown opcode, silent until chip select rises

module spi_ram_responder #(
  parameter int         ADDR_W    = 24,
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(ADDR_W) + 1;
  localparam logic [CNT_W-1:0] CNT_BYTE_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE     = ADDR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_IGNORE
  } state_t;

  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic cs_s1_q, cs_s2_q, cs_s3_q;
  logic mosi_s1_q, mosi_s2_q;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] rx_q, rx_d;
  logic [7:0]        tx_q;
  logic              rd_flavour_q;
  logic              miso_q;
  logic [ADDR_W-1:0] addr_q;
  logic              re_q, re_d1_q;
  logic              we_q;
  logic [7:0]        wdata_q;

  // Chip select idles high, so its synchronisers reset to 1 to keep busy low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_s3_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= spi_clk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      cs_s1_q   <= spi_cs_n;
      cs_s2_q   <= cs_s1_q;
      cs_s3_q   <= cs_s2_q;
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign cs_rise   = cs_s2_q & ~cs_s3_q;
  assign cs_fall   = ~cs_s2_q & cs_s3_q;

  assign rx_d = {rx_q[ADDR_W-2:0], mosi_s2_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      rd_flavour_q <= 1'b0;
      miso_q       <= 1'b0;
      addr_q       <= '0;
      re_q         <= 1'b0;
      re_d1_q      <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
    end else begin
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      re_d1_q <= re_q;

      // The write address advances one cycle after its strobe, even if cs has gone.
      if (we_q) begin
        addr_q <= addr_q + ADDR_ONE;
      end
      if (re_d1_q) begin
        tx_q <= mem_rdata;
      end

      case (state_q)
        ST_IDLE: begin
          cnt_q  <= '0;
          miso_q <= 1'b0;
          if (cs_fall) begin
            state_q <= ST_CMD;
          end
        end

        ST_CMD: begin
          if (sclk_rise) begin
            rx_q <= rx_d;
            if (cnt_q == CNT_BYTE_LAST) begin
              cnt_q <= '0;
              if (rx_d[7:0] == CMD_READ) begin
                rd_flavour_q <= 1'b1;
                state_q      <= ST_ADDR;
              end else if (rx_d[7:0] == CMD_WRITE) begin
                rd_flavour_q <= 1'b0;
                state_q      <= ST_ADDR;
              end else begin
                state_q <= ST_IGNORE;
              end
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end

        ST_ADDR: begin
          if (sclk_rise) begin
            rx_q <= rx_d;
            if (cnt_q == CNT_ADDR_LAST) begin
              cnt_q  <= '0;
              addr_q <= rx_d;
              if (rd_flavour_q) begin
                re_q    <= 1'b1;
                state_q <= ST_READ;
              end else begin
                state_q <= ST_WRITE;
              end
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end

        ST_READ: begin
          // The last bit of a byte goes out here, so fetch the next one now.
          if (sclk_fall) begin
            miso_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
            if (cnt_q == CNT_BYTE_LAST) begin
              cnt_q  <= '0;
              addr_q <= addr_q + ADDR_ONE;
              re_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end

        ST_WRITE: begin
          if (sclk_rise) begin
            rx_q <= rx_d;
            if (cnt_q == CNT_BYTE_LAST) begin
              cnt_q   <= '0;
              wdata_q <= rx_d[7:0];
              we_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end

        ST_IGNORE: begin
          miso_q <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          miso_q  <= 1'b0;
        end
      endcase

      // Deselect wins over everything except strobes already decided above.
      if (cs_rise) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        miso_q  <= 1'b0;
      end
    end
  end

  assign spi_miso  = miso_q;
  assign mem_addr  = addr_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign busy      = ~cs_s2_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Randomised scoreboard bench for spi_ram_responder: an SPI master drives transactions,
// a reference RAM predicts strobes and read data, and a monitor checks every strobe.

module tb_spi_ram_responder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [23:0] mem_addr;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        busy;

  typedef struct packed {
    logic [23:0] a;
    logic [7:0]  d;
  } wr_t;

  int          tests = 0;
  int          fails = 0;
  int          hp = 4;
  bit [7:0]    env_mem [int];
  bit [7:0]    ref_mem [int];
  logic [23:0] exp_rd_q [$];
  wr_t         exp_wr_q [$];
  bit [7:0]    wbuf [$];
  wr_t         mon_w;
  logic [23:0] mon_a;

  always #5 clk = ~clk;

  spi_ram_responder #(
    .ADDR_W   (24),
    .CMD_READ (8'h03),
    .CMD_WRITE(8'h02)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .spi_clk  (spi_clk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .mem_addr (mem_addr),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .busy     (busy)
  );

  // Contents of any location never written; both RAMs start from this image.
  function automatic bit [7:0] init_val(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic bit [7:0] ref_rd(input logic [23:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_re) begin
      mem_rdata <= env_mem.exists(int'(mem_addr)) ? env_mem[int'(mem_addr)] : init_val(mem_addr);
    end
    if (mem_we) begin
      env_mem[int'(mem_addr)] = mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (mem_re || mem_we) check("re_we_exclusive", 32'(mem_re & mem_we), 32'd0);
      if (mem_we) begin
        if (exp_wr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_we: addr %h data %h, no write required", mem_addr, mem_wdata);
        end else begin
          mon_w = exp_wr_q.pop_front();
          check("we_addr", 32'(mem_addr), 32'(mon_w.a));
          check("we_data", 32'(mem_wdata), 32'(mon_w.d));
        end
      end
      if (mem_re) begin
        if (exp_rd_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_re: addr %h, no read required", mem_addr);
        end else begin
          mon_a = exp_rd_q.pop_front();
          check("re_addr", 32'(mem_addr), 32'(mon_a));
        end
      end
    end
  end

  task automatic spi_bit(input bit b, output bit m);
    spi_mosi = b;
    repeat (hp) @(negedge clk);
    m = spi_miso;
    spi_clk = 1'b1;
    repeat (hp) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input bit [7:0] b, output bit [7:0] r);
    bit m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], m);
      r[i] = m;
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    repeat (hp) @(negedge clk);
    check("busy_active", 32'(busy), 32'd1);
  endtask

  task automatic cs_end(input int gap);
    repeat (hp) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_header(input bit [7:0] cmd, input logic [23:0] a);
    bit [7:0] r;
    bit [7:0] acc;
    spi_byte(cmd, r);
    acc = r;
    spi_byte(a[23:16], r);
    acc = acc | r;
    spi_byte(a[15:8], r);
    acc = acc | r;
    spi_byte(a[7:0], r);
    acc = acc | r;
    check("miso_header", 32'(acc), 32'd0);
  endtask

  task automatic do_write(input logic [23:0] a, input int gap);
    bit [7:0]    r;
    logic [23:0] ai;
    wr_t         w;
    cs_begin();
    send_header(8'h02, a);
    for (int i = 0; i < wbuf.size(); i++) begin
      ai = a + 24'(i);
      w.a = ai;
      w.d = wbuf[i];
      exp_wr_q.push_back(w);
      ref_mem[int'(ai)] = wbuf[i];
      spi_byte(wbuf[i], r);
    end
    cs_end(gap);
  endtask

  task automatic do_read(input logic [23:0] a, input int n, input int gap);
    bit [7:0] r;
    for (int k = 0; k <= n; k++) exp_rd_q.push_back(a + 24'(k));
    cs_begin();
    send_header(8'h03, a);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00, r);
      check("rd_byte", 32'(r), 32'(ref_rd(a + 24'(i))));
    end
    cs_end(gap);
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
    check("pending_we", 32'(exp_wr_q.size()), 32'd0);
    check("pending_re", 32'(exp_rd_q.size()), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("miso_idle", 32'(spi_miso), 32'd0);
    exp_wr_q.delete();
    exp_rd_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [7:0]    r;
    bit [7:0]    acc;
    bit          m;
    logic [23:0] a;
    int          n;

    repeat (3) @(negedge clk);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_re", 32'(mem_re), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    hp = 4;
    wbuf = '{8'hA5, 8'h3C};
    do_write(24'h000100, 8);
    drain();
    do_read(24'h000100, 2, 8);
    drain();

    do_read(24'hFFFFFF, 2, 8);
    drain();

    cs_begin();
    spi_byte(8'h9F, r);
    acc = r;
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'($urandom), r);
      acc = acc | r;
    end
    check("ignore_miso", 32'(acc), 32'd0);
    cs_end(8);
    drain();
    do_read(24'h000200, 1, 8);
    drain();

    cs_begin();
    send_header(8'h02, 24'h000010);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
    cs_end(8);
    drain();
    do_read(24'h000010, 1, 8);
    drain();

    a = 24'h0003F0;
    for (int k = 0; k <= 2; k++) exp_rd_q.push_back(a + 24'(k));
    cs_begin();
    send_header(8'h03, a);
    for (int i = 0; i < 2; i++) begin
      spi_byte(8'h00, r);
      check("rd_byte_prereset", 32'(r), 32'(ref_rd(a + 24'(i))));
    end
    for (int i = 0; i < 4; i++) spi_bit(1'b0, m);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_miso", 32'(spi_miso), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    check("midrst_re", 32'(mem_re), 32'd0);
    check("midrst_we", 32'(mem_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_reads_seen", 32'(exp_rd_q.size()), 32'd0);
    spi_cs_n = 1'b1;
    spi_clk = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    exp_rd_q.delete();
    do_read(24'h000000, 1, 8);
    drain();

    for (int t = 0; t < 6; t++) begin
      hp = int'($urandom_range(4, 6));
      a = (t == 2) ? 24'hFFFFFE : 24'($urandom);
      n = int'($urandom_range(1, 4));
      wbuf.delete();
      for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom));
      do_write(a, 8);
      drain();
      do_read(a, n, 8);
      drain();
    end

    hp = 4;
    for (int t = 0; t < 3; t++) begin
      a = 24'($urandom);
      n = int'($urandom_range(1, 3));
      wbuf.delete();
      for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom));
      do_write(a, 2);
      do_read(a, n, 2);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_ram_responder.md
Name: spi_ram_responder

Overview:
SPI mode-0 slave that answers the femto core's SPI RAM master port (spi_clk_ram / spi_cs_n_ram / spi_mosi_ram / spi_miso_ram). It emulates a 23LC-style serial SRAM with READ and WRITE commands, a 24-bit address and sequential auto-increment. It backs onto a simple synchronous memory port, so an FPGA or test harness can supply RAM to the core without an external chip. All SPI inputs are oversampled in the clk domain; there is no logic clocked by spi_clk.

Parameters:
ADDR_W, 24, address bits shifted in after the command (MSB first); the internal address counter is ADDR_W wide.
CMD_READ, 8'h03, opcode for sequential read.
CMD_WRITE, 8'h02, opcode for sequential write.

Ports:
clk  input  1  system clock; all state on posedge clk.
resetn  input  1  asynchronous active-low reset.
spi_clk  input  1  SPI clock from master; idles low.
spi_cs_n  input  1  SPI chip select, active low.
spi_mosi  input  1  master-to-slave data.
spi_miso  output  1  slave-to-master data.
mem_addr  output  ADDR_W  memory address.
mem_re  output  1  one-cycle read strobe.
mem_rdata  input  8  read data, valid exactly 1 clk after mem_re.
mem_we  output  1  one-cycle write strobe.
mem_wdata  output  8  write data, valid while mem_we=1.
busy  output  1  high while cs_n (synchronised) is low.

Behaviour:
- Reset values: spi_miso=0, mem_addr=0, mem_re=0, mem_we=0, mem_wdata=0, busy=0, FSM=IDLE, bit counter=0.
- Sync: spi_clk, spi_cs_n and spi_mosi each pass through 2 flops. Edge detect uses the synced spi_clk against a third flop. Rise/fall pulses are 1 clk wide.
- Constraint: SPI half-period must be at least 4 clk cycles. Behaviour is undefined below this.
- Bits are sampled on rise, MSB first. spi_miso updates on fall.
- FSM states: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
- IDLE: moves to CMD when synced cs_n goes low. The bit counter clears.
- CMD: after 8 rises, compare the shifted opcode:
  - CMD_READ -> ADDR (read flavour).
  - CMD_WRITE -> ADDR (write flavour).
  - Any other opcode -> IGNORE.
- ADDR: after ADDR_W rises, mem_addr is loaded with the shifted address.
  - Read flavour: mem_re pulses on the cycle after the last rise, then -> READ.
  - Write flavour: -> WRITE.
- READ:
  - The cycle after mem_re, mem_rdata loads the tx shift register.
  - Each fall shifts out the next bit onto spi_miso (bit7 on the first fall).
  - On the 8th fall of a byte, mem_addr increments and mem_re pulses, prefetching the next byte before its first fall.
  - mem_rdata loads on the following cycle.
- WRITE:
  - On the 8th rise of a data byte, mem_wdata gets the assembled byte and mem_we pulses on the next cycle at the current mem_addr.
  - mem_addr increments on the cycle after mem_we.
- Address wrap: increment is modulo 2^ADDR_W, so the address after all-ones is 0.
- IGNORE: spi_miso=0 and no memory strobes until cs_n goes high.
- cs_n deassert (synced rise) in any state:
  - Next cycle -> IDLE, spi_miso=0, counter cleared.
  - A partially received write byte is discarded; no mem_we is issued.
  - A mem_we or mem_re already pulsed stands.
- cs_n deassert coinciding with the 8th rise of a write byte: the byte completed before deassert, so it is written.
- mem_re and mem_we are never both high. Each is at most 1 clk wide.
- spi_miso is 0 outside READ.
- busy = NOT synced cs_n.
- Asynchronous reset mid-transaction returns everything to the reset values immediately. The master must reassert cs_n to begin a new command.

Test Plan:
- Write then read, half-period 4 clk: send 02 00 01 00 A5 3C, deassert cs_n. Required: mem_we twice, (0x000100, A5) then (0x000101, 3C). Then send 03 00 01 00 plus 16 dummy clocks. Required: spi_miso returns A5 then 3C, and mem_re is seen at 0x000100 and 0x000101.
- Address wrap: READ at 0xFFFFFF for 2 bytes. Required: mem_re at 0xFFFFFF then 0x000000.
- Unknown opcode 0x9F followed by 32 clocks. Required: no mem_re or mem_we, spi_miso stuck at 0, FSM back in IDLE after cs_n goes high.
- Aborted write: send 02 00 00 10 followed by 5 bits of 0xFF, then cs_n high. Required: no mem_we. A following READ of 0x000010 issues a clean mem_re with no spurious strobe.
- Reset mid-read: assert resetn=0 during the 3rd data byte. Required: all outputs return to reset values in the same cycle. After release, a new 03 000000 transaction returns the correct first byte.
- Back-to-back transactions with a 2-clk cs_n high gap, run at the minimum half-period of 4 clk. Required: both transactions complete correctly.
